viterbi_mux_reg: RTL and testbench

//   Parametrised, registered N-way select for the Viterbi datapath. Picks one of
//   NUM_IN WIDTH-bit lanes (branch/path-metric or survivor bits) and presents it

---
 rtl/viterbi_mux_reg.sv | 115 +++++++++++
 tb/tb_viterbi_mux_reg.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_mux_reg.sv
// Registered NUM_IN-way lane select with valid/ready output stage and sticky range error.
// Optional handshake counter port xfer_cnt is enabled by defining VITERBI_MUX_CNT_EN.
module viterbi_mux_reg #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    clr_err
`ifdef VITERBI_MUX_CNT_EN
  ,
  output logic [15:0]             xfer_cnt
`endif
);

  logic [WIDTH-1:0] lane_sel;
  logic             sel_hit;
  logic             accept;
  logic             pop;

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Compare against each legal index so a non-power-of-two lane count never
  // indexes past the bus; no hit means sel is out of range.
  always_comb begin
    lane_sel = '0;
    sel_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        lane_sel = in_bus[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = valid_q && out_ready;

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (accept) begin
      data_d  = sel_hit ? lane_sel : '0;
      sel_d   = sel;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (accept && !sel_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;

`ifdef VITERBI_MUX_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_err) begin
      cnt_d = '0;
    end else if (pop && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_mux_reg.sv
// Bench for viterbi_mux_reg: table-driven scoreboard on a default instance plus
// hand-written range/error and counter sequences on a 5-lane 8-bit instance.
module tb_viterbi_mux_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance: WIDTH=2, NUM_IN=4, SEL_W=2
  logic [7:0] in_bus;
  logic [1:0] sel, out_data, out_sel;
  logic       in_valid, in_ready, out_valid, out_ready, sel_err, clr_err;

  // Range instance: WIDTH=8, NUM_IN=5, SEL_W=3
  logic [39:0] in_bus5;
  logic [2:0]  sel5, out_sel5;
  logic [7:0]  out_data5;
  logic        in_valid5, in_ready5, out_valid5, out_ready5, sel_err5, clr_err5;

`ifdef VITERBI_MUX_CNT_EN
  logic [15:0] xfer_cnt, xfer_cnt5;
`endif

  viterbi_mux_reg u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .clr_err   (clr_err)
`ifdef VITERBI_MUX_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  viterbi_mux_reg #(
    .WIDTH  (8),
    .NUM_IN (5),
    .SEL_W  (3)
  ) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus5),
    .sel       (sel5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .out_data  (out_data5),
    .out_sel   (out_sel5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .sel_err   (sel_err5),
    .clr_err   (clr_err5)
`ifdef VITERBI_MUX_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt5)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic       rdy;
    logic [1:0] exp_data;
    logic       exp_in_ready;
  } vec_t;

  typedef struct packed {
    logic [1:0] s;
    logic [1:0] d;
  } sb_t;

  vec_t vecs[15];
  sb_t  sbq[$];
  sb_t  sb_item;

  // Bench-side model of the output register
  logic       ov_m;
  logic [1:0] last_d_m, last_s_m;

  task automatic model_reset();
    ov_m     = 1'b0;
    last_d_m = 2'd0;
    last_s_m = 2'd0;
    sbq.delete();
  endtask

  initial begin
    logic acc_m, pop_m;

    // Lanes {3,2,1,0}: lane k carries value k
    vecs[0]  = '{1'b1, 2'd0, 1'b1, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 2'd1, 1'b1, 2'd1, 1'b1};
    vecs[2]  = '{1'b1, 2'd2, 1'b1, 2'd2, 1'b1};
    vecs[3]  = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b1};
    vecs[5]  = '{1'b1, 2'd2, 1'b1, 2'd2, 1'b1};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 1'b1, 2'd1, 1'b1};
    vecs[10] = '{1'b0, 2'd3, 1'b1, 2'd3, 1'b1};
    vecs[11] = '{1'b1, 2'd3, 1'b0, 2'd3, 1'b1};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b1};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b1};

    rst_n     = 1'b0;
    in_bus    = {2'd3, 2'd2, 2'd1, 2'd0};
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    in_bus5   = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    sel5      = '0;
    in_valid5 = 1'b0;
    out_ready5 = 1'b0;
    clr_err5  = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table run with scoreboard on the default instance
    for (int i = 0; i < 15; i++) begin
      in_valid  = vecs[i].v;
      sel       = vecs[i].s;
      out_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_in_ready);
      chk($sformatf("v%0d_out_valid", i), out_valid, ov_m);
      chk($sformatf("v%0d_out_data", i), out_data, last_d_m);
      chk($sformatf("v%0d_out_sel", i), out_sel, last_s_m);
      chk($sformatf("v%0d_sel_err", i), sel_err, 0);
      acc_m = vecs[i].v && (!ov_m || vecs[i].rdy);
      pop_m = ov_m && vecs[i].rdy;
      if (pop_m) begin
        if (sbq.size() == 0) begin
          chk($sformatf("v%0d_sb_empty", i), 1, 0);
        end else begin
          sb_item = sbq.pop_front();
          chk($sformatf("v%0d_sb_data", i), out_data, sb_item.d);
          chk($sformatf("v%0d_sb_sel", i), out_sel, sb_item.s);
        end
      end
      if (acc_m) sbq.push_back('{s: vecs[i].s, d: vecs[i].exp_data});
      @(posedge clk);
      #1;
      if (acc_m) begin
        ov_m     = 1'b1;
        last_d_m = vecs[i].exp_data;
        last_s_m = vecs[i].s;
      end else if (pop_m) begin
        ov_m = 1'b0;
      end
    end
    chk("sb_drained", sbq.size(), 0);

    // Reset while an output word is held under backpressure
    in_valid  = 1'b1;
    sel       = 2'd2;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_sel_err", sel_err, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Range/error sequence on the 5-lane instance
    in_valid5 = 1'b1; sel5 = 3'd4; out_ready5 = 1'b1;
    @(posedge clk); #1;
    chk("r_a_data", out_data5, 8'hA4);
    chk("r_a_sel", out_sel5, 4);
    chk("r_a_valid", out_valid5, 1);
    chk("r_a_err", sel_err5, 0);
    sel5 = 3'd6; out_ready5 = 1'b0;
    #1;
    chk("r_b_in_ready", in_ready5, 0);
    @(posedge clk); #1;
    chk("r_b_data_hold", out_data5, 8'hA4);
    chk("r_b_err", sel_err5, 0);
    out_ready5 = 1'b1;
    @(posedge clk); #1;
    chk("r_c_data", out_data5, 8'h00);
    chk("r_c_sel", out_sel5, 6);
    chk("r_c_valid", out_valid5, 1);
    chk("r_c_err", sel_err5, 1);
    in_valid5 = 1'b0;
    @(posedge clk); #1;
    chk("r_d_valid", out_valid5, 0);
    chk("r_d_sel_hold", out_sel5, 6);
    chk("r_d_err_sticky", sel_err5, 1);
    in_valid5 = 1'b1; sel5 = 3'd7; clr_err5 = 1'b1;
    @(posedge clk); #1;
    chk("r_e_err_set_wins", sel_err5, 1);
    chk("r_e_sel", out_sel5, 7);
    chk("r_e_data", out_data5, 8'h00);
    in_valid5 = 1'b0;
    @(posedge clk); #1;
    chk("r_f_err_cleared", sel_err5, 0);
    chk("r_f_valid", out_valid5, 0);
    clr_err5 = 1'b0;

`ifdef VITERBI_MUX_CNT_EN
    chk("cnt_cleared", xfer_cnt5, 0);
    in_valid5 = 1'b1; sel5 = 3'd1;
    repeat (10) @(posedge clk);
    in_valid5 = 1'b0;
    @(posedge clk); #1;
    chk("cnt_ten", xfer_cnt5, 10);
    in_valid5 = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("cnt_saturate", xfer_cnt5, 16'hFFFF);
    @(posedge clk); #1;
    chk("cnt_hold_max", xfer_cnt5, 16'hFFFF);
    clr_err5 = 1'b1;
    @(posedge clk); #1;
    chk("cnt_clr_wins", xfer_cnt5, 0);
    clr_err5 = 1'b0; in_valid5 = 1'b0;
    @(posedge clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
